// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle control FSM for the 32-bit MIPS-subset datapath
module mc_control #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       Zero,
    output logic       PCWr,
    output logic [1:0] nPC_sel,
    output logic       IRWr,
    output logic       RegWr,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       MemRd,
    output logic       MemWr,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic [2:0] ALUctr,
    output logic       illegal,
    output logic       instr_done
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EXE_R, S_WB_R, S_EXE_I, S_WB_I,
        S_ADDR, S_MEM_RD, S_WB_LD, S_MEM_WR, S_BR, S_JMP
    } state_t;

    state_t     state;
    state_t     id_next;
    logic [3:0] wait_cnt;
    logic [5:0] op_q;
    logic [5:0] func_q;
    logic       mem_last;

    // S_IF doubles as the "undecodable" marker for the ID successor.
    function automatic state_t decode_next(input logic [5:0] o, input logic [5:0] f);
        state_t s;
        s = S_IF;
        case (o)
            OP_RTYPE: if (f == FN_ADD || f == FN_ADDU || f == FN_SUB || f == FN_SUBU) s = S_EXE_R;
            OP_ORI:   s = S_EXE_I;
            OP_LW:    s = S_ADDR;
            OP_SW:    s = S_ADDR;
            OP_BEQ:   s = S_BR;
            OP_J:     s = S_JMP;
            default:  s = S_IF;
        endcase
        return s;
    endfunction

    assign id_next  = decode_next(op, func);
    assign mem_last = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IF;
            wait_cnt <= 4'd0;
            op_q     <= 6'd0;
            func_q   <= 6'd0;
        end else begin
            case (state)
                S_IF: begin
                    if (mem_last) begin
                        state    <= S_ID;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ID: begin
                    op_q   <= op;
                    func_q <= func;
                    state  <= id_next;
                end
                S_EXE_R: state <= S_WB_R;
                S_EXE_I: state <= S_WB_I;
                S_ADDR:  state <= (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (mem_last) begin
                        state    <= S_WB_LD;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_MEM_WR: begin
                    if (mem_last) begin
                        state    <= S_IF;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: state <= S_IF;
            endcase
        end
    end

    always_comb begin
        PCWr       = 1'b0;
        nPC_sel    = 2'b00;
        IRWr       = 1'b0;
        RegWr      = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        MemRd      = 1'b0;
        MemWr      = 1'b0;
        ALUSrc     = 1'b0;
        ExtOp      = 1'b0;
        ALUctr     = 3'b001;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state)
            S_IF: begin
                PCWr = mem_last;
                IRWr = mem_last;
            end
            S_ID: begin
                ExtOp = (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
                if (id_next == S_IF) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_EXE_R, S_WB_R: begin
                RegDst = 1'b1;
                case (func_q)
                    FN_ADD:  ALUctr = 3'b000;
                    FN_ADDU: ALUctr = 3'b001;
                    FN_SUB:  ALUctr = 3'b010;
                    FN_SUBU: ALUctr = 3'b011;
                    default: ALUctr = 3'b001;
                endcase
                RegWr      = (state == S_WB_R);
                instr_done = (state == S_WB_R);
            end
            S_EXE_I, S_WB_I: begin
                ALUSrc     = 1'b1;
                ALUctr     = 3'b100;
                RegWr      = (state == S_WB_I);
                instr_done = (state == S_WB_I);
            end
            S_ADDR, S_MEM_RD, S_WB_LD, S_MEM_WR: begin
                ALUSrc   = 1'b1;
                ExtOp    = 1'b1;
                ALUctr   = 3'b000;
                MemRd    = (state == S_MEM_RD);
                MemWr    = (state == S_MEM_WR);
                MemtoReg = (state == S_WB_LD);
                RegWr    = (state == S_WB_LD);
                instr_done = (state == S_WB_LD) || (state == S_MEM_WR && mem_last);
            end
            S_BR: begin
                ExtOp      = 1'b1;
                ALUctr     = 3'b010;
                nPC_sel    = 2'b01;
                PCWr       = Zero;
                instr_done = 1'b1;
            end
            S_JMP: begin
                PCWr       = 1'b1;
                nPC_sel    = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides everything so an abandoned instruction never strobes.
        if (!rst_n) begin
            PCWr       = 1'b0;
            nPC_sel    = 2'b00;
            IRWr       = 1'b0;
            RegWr      = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            MemRd      = 1'b0;
            MemWr      = 1'b0;
            ALUSrc     = 1'b0;
            ExtOp      = 1'b0;
            ALUctr     = 3'b000;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule
